mem_wb_pipe: RTL and testbench
==============================

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning ALU-result and memory-data width.
REQ-002 SHALL have parameter RD_W, default 5, meaning destination-register index width.
REQ-003 SHALL have one clock, clk; reset is synchronous and active-high, port rst.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held entries
- in_valid  in  1  upstream (MEM) entry offered
- in_ready  out  1  block can accept an entry this cycle
- in_alu_c  in  DATA_W  ALU result
- in_dm_data  in  DATA_W  data-memory read data
- in_rd  in  RD_W  destination register
- in_regw  in  1  register-write enable
- in_mem2r  in  1  write-back selects memory data
- out_valid  out  1  head entry valid toward WB
- out_ready  in  1  WB consumes head entry
- out_alu_c, out_dm_data  out  DATA_W  head payload
- out_rd  out  RD_W  head destination
- out_regw  out  1  head write enable, gated by out_valid
- out_mem2r  out  1  head select
- out_wdata  out  DATA_W  out_mem2r ? out_dm_data : out_alu_c
- fwd_en  out  1  out_valid & out_regw & (out_rd != 0)
- occupancy  out  2  entries held (0..2)

Function
REQ-005 SHALL hold entries in a two-slot skid buffer (head, skid) with states EMPTY, ONE, FULL; occupancy equals 0, 1 or 2 respectively.
REQ-006 SHALL drive in_ready from a register, equal to (state != FULL); in_ready SHALL NOT combinationally depend on out_ready.
REQ-007 SHALL accept an entry on a rising edge when in_valid & in_ready; SHALL retire the head when out_valid & out_ready.
REQ-008 Transitions: EMPTY+accept -> ONE; ONE+accept+no retire -> FULL; ONE+retire+no accept -> EMPTY; ONE+accept+retire -> ONE (new entry becomes head); FULL+retire -> ONE (skid moves to head); otherwise hold.
REQ-009 SHALL give one-cycle latency: an entry accepted at edge N appears on outputs after edge N when the buffer was EMPTY or the head retired at edge N.
REQ-010 SHALL preserve entry order; no entry may be duplicated or dropped except by flush or rst.
REQ-011 SHALL force the stored regw bit to 0 when in_rd == 0 at capture.
REQ-012 SHALL drive out_regw and fwd_en to 0 whenever out_valid is 0, regardless of stored payload.
REQ-013 SHALL hold payload outputs stable while out_valid & !out_ready.
REQ-014 Flush: at the edge where flush is 1, state -> EMPTY and any same-cycle accept or retire SHALL be ignored; in_ready SHALL be 1 after that edge.
REQ-015 Flush has priority below rst and above all handshakes.

Reset
REQ-016 On rst at a rising edge: state EMPTY, occupancy 0, out_valid 0, in_ready 1, out_regw 0, fwd_en 0, all payload registers 0.
REQ-017 rst asserted mid-transfer SHALL discard all entries identically to REQ-016; no output changes before the edge.

Structure
REQ-018 Shared package SHALL hold the state enum (EMPTY, ONE, FULL) and the payload struct (alu_c, dm_data, rd, regw, mem2r) sized by DATA_W/RD_W defaults.
REQ-019 One sub-module wb_data_sel (combinational write-back mux producing out_wdata) is natural; slot storage stays in mem_wb_pipe.

Verification
REQ-020 rst, then in_valid=1, alu_c=0x11, rd=3, regw=1, mem2r=0, out_ready=1 -> next cycle out_valid=1, out_wdata=0x11, fwd_en=1, occupancy=1.
REQ-021 out_ready=0, push A(0xA), B(0xB) -> occupancy=2, in_ready=0; third push ignored; raise out_ready -> A then B on consecutive cycles, in_ready=1 after A retires.
REQ-022 push rd=0, regw=1, alu_c=0x5 -> out_regw=0, fwd_en=0, out_valid=1.
REQ-023 mem2r=1, dm_data=0xDEADBEEF, alu_c=0x4 -> out_wdata=0xDEADBEEF.
REQ-024 FULL, assert flush with in_valid=1 and out_ready=1 same cycle -> next cycle occupancy=0, out_valid=0, in_ready=1, flushed inputs never appear.
REQ-025 Continuous in_valid=1, out_ready=1 for 8 entries 0..7 -> outputs 0..7 in order, one per cycle, occupancy constant 1.

Source files
------------

// File: rtl/mem_wb_pipe_pkg.sv
// Shared types for the MEM/WB pipeline register: buffer state encoding and
// the default-sized write-back payload record.
package mem_wb_pipe_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_RD_W   = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] alu_c;
    logic [DEF_DATA_W-1:0] dm_data;
    logic [DEF_RD_W-1:0]   rd;
    logic                  regw;
    logic                  mem2r;
  } wb_payload_t;

  function automatic logic [1:0] state_occupancy(input pipe_state_e st);
    logic [1:0] occ;
    case (st)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_wb_data_sel.sv
// Write-back data select: memory read data or ALU result.
module wb_data_sel #(
  parameter int DATA_W = 32
) (
  input  logic              sel_mem,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [DATA_W-1:0] dm_data,
  output logic [DATA_W-1:0] wdata
);

  // pick the write-back source
  always_comb begin
    wdata = alu_c;
    if (sel_mem) begin
      wdata = dm_data;
    end else begin
      wdata = alu_c;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register built as a two-slot skid buffer (head + skid) so
// that in_ready comes straight from a flop and never from out_ready.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_c,
  input  logic [DATA_W-1:0] in_dm_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_regw,
  input  logic              in_mem2r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_c,
  output logic [DATA_W-1:0] out_dm_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_regw,
  output logic              out_mem2r,
  output logic [DATA_W-1:0] out_wdata,
  output logic              fwd_en,
  output logic [1:0]        occupancy
);

  import mem_wb_pipe_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0] alu_c;
    logic [DATA_W-1:0] dm_data;
    logic [RD_W-1:0]   rd;
    logic              regw;
    logic              mem2r;
  } slot_t;

  pipe_state_e state_q, state_d;
  slot_t       head_q, head_d;
  slot_t       skid_q, skid_d;
  slot_t       cap_s;
  logic        in_ready_q, in_ready_d;
  logic        accept_s, retire_s, out_valid_s;

  // capture record; a write to r0 is never a real write
  always_comb begin
    cap_s.alu_c   = in_alu_c;
    cap_s.dm_data = in_dm_data;
    cap_s.rd      = in_rd;
    cap_s.regw    = in_regw & (in_rd != {RD_W{1'b0}});
    cap_s.mem2r   = in_mem2r;
  end

  assign out_valid_s = (state_q != EMPTY);
  assign accept_s    = in_valid & in_ready_q;
  assign retire_s    = out_valid_s & out_ready;

  // next state and slot movement; flush overrides every handshake
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            head_d  = cap_s;
            state_d = ONE;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && retire_s) begin
            head_d  = cap_s;
            state_d = ONE;
          end else if (accept_s) begin
            skid_d  = cap_s;
            state_d = FULL;
          end else if (retire_s) begin
            state_d = EMPTY;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (retire_s) begin
            head_d  = skid_q;
            state_d = ONE;
          end else begin
            state_d = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  // state, slots and the registered ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_q     <= {$bits(slot_t){1'b0}};
      skid_q     <= {$bits(slot_t){1'b0}};
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_s;
  assign out_alu_c   = head_q.alu_c;
  assign out_dm_data = head_q.dm_data;
  assign out_rd      = head_q.rd;
  assign out_mem2r   = head_q.mem2r;
  assign out_regw    = out_valid_s & head_q.regw;
  assign fwd_en      = out_valid_s & head_q.regw & (head_q.rd != {RD_W{1'b0}});
  assign occupancy   = state_occupancy(state_q);

  wb_data_sel #(
    .DATA_W (DATA_W)
  ) u_wb_data_sel (
    .sel_mem (head_q.mem2r),
    .alu_c   (head_q.alu_c),
    .dm_data (head_q.dm_data),
    .wdata   (out_wdata)
  );

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed vector table, an in-order
// streaming sequence, then random traffic against a queue-based model.
module tb_mem_wb_pipe;
  import mem_wb_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_c;
  logic [31:0] in_dm_data;
  logic [4:0]  in_rd;
  logic        in_regw;
  logic        in_mem2r;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_c;
  logic [31:0] out_dm_data;
  logic [4:0]  out_rd;
  logic        out_regw;
  logic        out_mem2r;
  logic [31:0] out_wdata;
  logic        fwd_en;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_pipe #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_c(in_alu_c), .in_dm_data(in_dm_data), .in_rd(in_rd),
    .in_regw(in_regw), .in_mem2r(in_mem2r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_c(out_alu_c), .out_dm_data(out_dm_data), .out_rd(out_rd),
    .out_regw(out_regw), .out_mem2r(out_mem2r), .out_wdata(out_wdata),
    .fwd_en(fwd_en), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] alu, dm;
    logic [4:0]  rd;
    logic        regw, mem2r, ordy;
    logic        e_ov;
    logic [1:0]  e_occ;
    logic        e_ir;
    logic [31:0] e_wdata;
    logic [4:0]  e_rd;
    logic        e_regw, e_fwd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] alu,
                              logic [31:0] dm, logic [4:0] rd, logic regw,
                              logic mem2r, logic ordy, logic e_ov, logic [1:0] e_occ,
                              logic e_ir, logic [31:0] e_wdata, logic [4:0] e_rd,
                              logic e_regw, logic e_fwd);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.alu = alu; v.dm = dm; v.rd = rd;
    v.regw = regw; v.mem2r = mem2r; v.ordy = ordy; v.e_ov = e_ov;
    v.e_occ = e_occ; v.e_ir = e_ir; v.e_wdata = e_wdata; v.e_rd = e_rd;
    v.e_regw = e_regw; v.e_fwd = e_fwd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [4:0] rd, input logic regw,
                       input logic mem2r, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_alu_c = alu; in_dm_data = dm;
    in_rd = rd; in_regw = regw; in_mem2r = mem2r; out_ready = ordy;
  endtask

  wb_payload_t mq[$];
  wb_payload_t ent;
  wb_payload_t hd;
  logic        r_rst, r_flush, r_iv, r_regw, r_mem2r, r_ordy;
  logic [31:0] r_alu, r_dm;
  logic [4:0]  r_rd;
  logic [31:0] exp_w;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    //          rst   fl    iv    alu           dm            rd    rw    m2r   ordy  ov    occ   ir    wdata         rd    regw  fwd
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h11, 32'h0,        5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h11,       5'd3, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'hA,  32'h0,        5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'hA,        5'd1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'hB,  32'h0,        5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'hA,        5'd1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'hC,  32'h0,        5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'hA,        5'd1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hB,        5'd2, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h5,  32'h0,        5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h5,        5'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h4,  32'hDEADBEEF, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 32'hDEADBEEF, 5'd7, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h21, 32'h0,        5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 5'd7, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 32'h99, 32'h0,        5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h31, 32'h0,        5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h31,       5'd1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 32'h32, 32'h0,        5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h41, 32'h0,        5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h41,       5'd1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 32'h42, 32'h0,        5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].alu, tbl[i].dm,
            tbl[i].rd, tbl[i].regw, tbl[i].mem2r, tbl[i].ordy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d out_regw", i), 32'(out_regw), 32'(tbl[i].e_regw));
      chk($sformatf("vec%0d fwd_en", i), 32'(fwd_en), 32'(tbl[i].e_fwd));
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d out_wdata", i), out_wdata, tbl[i].e_wdata);
        chk($sformatf("vec%0d out_rd", i), 32'(out_rd), 32'(tbl[i].e_rd));
      end
    end

    // streaming: one entry in and one out every cycle, strictly in order
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'(i), 32'hFFFF0000, 5'(i + 1), 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d out_wdata", i), out_wdata, 32'(i));
      chk($sformatf("stream%0d occupancy", i), 32'(occupancy), 32'd1);
      chk($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("stream drain occupancy", 32'(occupancy), 32'd0);

    // random traffic against a FIFO-of-depth-2 model
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      r_rst   = ($urandom_range(0, 59) == 0);
      r_flush = ($urandom_range(0, 24) == 0);
      r_iv    = ($urandom_range(0, 3) != 0);
      r_alu   = $urandom;
      r_dm    = $urandom;
      r_rd    = 5'($urandom_range(0, 3));
      r_regw  = 1'($urandom_range(0, 1));
      r_mem2r = 1'($urandom_range(0, 1));
      r_ordy  = ($urandom_range(0, 2) != 0);
      drive(r_rst, r_flush, r_iv, r_alu, r_dm, r_rd, r_regw, r_mem2r, r_ordy);

      if (r_rst || r_flush) begin
        mq.delete();
      end else begin
        ent.alu_c   = r_alu;
        ent.dm_data = r_dm;
        ent.rd      = r_rd;
        ent.regw    = r_regw && (r_rd != 5'd0);
        ent.mem2r   = r_mem2r;
        if (r_iv && mq.size() < 2) begin
          if (mq.size() > 0 && r_ordy) void'(mq.pop_front());
          mq.push_back(ent);
        end else if (mq.size() > 0 && r_ordy) begin
          void'(mq.pop_front());
        end
      end

      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d occupancy", c), 32'(occupancy), 32'(mq.size()));
      chk($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(mq.size() > 0));
      chk($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(mq.size() < 2));
      if (mq.size() > 0) begin
        hd    = mq[0];
        exp_w = hd.mem2r ? hd.dm_data : hd.alu_c;
        chk($sformatf("rnd%0d out_wdata", c), out_wdata, exp_w);
        chk($sformatf("rnd%0d out_alu_c", c), out_alu_c, hd.alu_c);
        chk($sformatf("rnd%0d out_rd", c), 32'(out_rd), 32'(hd.rd));
        chk($sformatf("rnd%0d out_regw", c), 32'(out_regw), 32'(hd.regw));
        chk($sformatf("rnd%0d fwd_en", c), 32'(fwd_en), 32'(hd.regw && hd.rd != 5'd0));
      end else begin
        chk($sformatf("rnd%0d idle out_regw", c), 32'(out_regw), 32'd0);
        chk($sformatf("rnd%0d idle fwd_en", c), 32'(fwd_en), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
